dmem_stall_unit: RTL and testbench

Multi-cycle data-memory front end for the MEM stage of the 5-stage pipelined processor. It accepts one load or store per instruction from the MEM stage and drives a fixed-latency backing memory. It holds the pipeline with `stall` until the access completes, then returns load data with a one-cycle `done` pulse. It replaces the single-cycle memory path and traps illegal accesses on `err`, which `proc` ORs into its global error.

---
 rtl/dmem_stall_unit.sv | 171 +++++++++++++++++
 tb/tb_dmem_stall_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stall_unit.sv
// dmem_stall_unit: multi-cycle data-memory front end for the MEM stage.
//
// Takes one load or store from the MEM stage and drives a fixed-latency
// backing memory. The pipeline is held with `stall` until the access
// completes, then `done` pulses for one cycle with the load result on
// `read_data`. Illegal requests set a sticky `err`.
//
// Optional feature: define DMEM_ALIGN_CHECK_EN to trap loads/stores with
// addr[0]==1 as illegal. The default build ignores addr[0].
//
// Parameters:
//   LATENCY     backing-memory access time in cycles (1..15)
//   ADDR_W      address width
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   addr        MEM-stage address
//   write_data  MEM-stage store data
//   MEM_READ    MEM stage holds a load
//   MEM_WRITE   MEM stage holds a store
//   HALT        halt reached WB; blocks new requests in idle
//   mem_rdata   backing-memory read data
//   stall       freeze IF/ID/EX/MEM pipeline registers
//   done        one-cycle completion pulse
//   read_data   registered load result, held until the next load completes
//   mem_addr    latched request address
//   mem_wdata   latched store data
//   mem_rd      one-cycle read strobe
//   mem_wr      one-cycle write strobe
//   err         sticky illegal-access flag

module dmem_stall_unit #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       write_data,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic              HALT,
  input  logic [15:0]       mem_rdata,
  output logic              stall,
  output logic              done,
  output logic [15:0]       read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              err
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic misalign;
  logic req_legal;
  logic req_illegal;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  assign misalign = 1'b0;
`endif

  // HALT suppresses both legal and illegal requests: nothing new is decoded
  // once the halt instruction has retired.
  assign req_legal   = (MEM_READ ^ MEM_WRITE) & ~HALT & ~misalign;
  assign req_illegal = ~HALT & ((MEM_READ & MEM_WRITE) | ((MEM_READ | MEM_WRITE) & misalign));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_legal) begin
          state_d  = StBusy;
          addr_d   = addr;
          wdata_d  = write_data;
          op_wr_d  = MEM_WRITE;
          mem_rd_d = MEM_READ;
          mem_wr_d = MEM_WRITE;
          cnt_d    = 4'(LATENCY - 1);
        end else if (req_illegal) begin
          err_d = 1'b1;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!op_wr_q) begin
            rdata_d = mem_rdata;
          end
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        // Instruction still sits in MEM this cycle, so no new request here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      op_wr_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'd0;
      rdata_q  <= 16'd0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // stall is combinational so the pipeline freezes in the request cycle;
  // gated by rst so every output reads 0 while reset is held.
  assign stall     = rst & (((state_q == StIdle) & req_legal) | (state_q == StBusy));
  assign done      = done_q;
  assign read_data = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_stall_unit.sv
// Self-checking bench for dmem_stall_unit: directed cases plus randomized
// load/store/nop traffic against a reference memory, with a scoreboard
// monitor checking strobes and completions.
module tb_dmem_stall_unit;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] write_data;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic        HALT;
  logic [15:0] mem_rdata;
  logic        stall;
  logic        done;
  logic [15:0] read_data;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic        err;

  dmem_stall_unit #(
    .LATENCY(LAT),
    .ADDR_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .write_data(write_data),
    .MEM_READ  (MEM_READ),
    .MEM_WRITE (MEM_WRITE),
    .HALT      (HALT),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .done      (done),
    .read_data (read_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'((i * 16'h0101) ^ 16'h5A5A);
  endfunction

  // Backing memory: read data is garbage until LAT cycles after acceptance.
  logic [15:0] bmem [0:255];
  bit          bmem_init;
  logic [7:0]  rd_idx;
  int unsigned rd_age;

  always @(posedge clk) begin
    if (!bmem_init) begin
      for (int i = 0; i < 256; i++) bmem[i] <= init_word(i);
      bmem_init <= 1'b1;
    end else if (mem_wr) begin
      bmem[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_rd) begin
      rd_idx <= mem_addr[7:0];
      rd_age <= 2;
    end else if (rd_age < 1000) begin
      rd_age <= rd_age + 1;
    end
  end

  always_comb begin
    mem_rdata = 16'hDEAD;
    if (mem_rd) begin
      if (LAT <= 1) mem_rdata = bmem[mem_addr[7:0]];
    end else if (rd_age >= LAT) begin
      mem_rdata = bmem[rd_idx];
    end
  end

  // Reference model and scoreboard.
  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } strobe_t;
  typedef struct packed {
    logic        wr;
    logic [15:0] rdata;
  } resp_t;

  strobe_t     sq[$];
  resp_t       rq[$];
  logic [15:0] ref_mem [0:255];
  logic [15:0] model_rd;
  logic        exp_err;

  always @(negedge clk) begin
    if (!rst) begin
      sq.delete();
      rq.delete();
    end else begin
      check("err", {31'd0, err}, {31'd0, exp_err});
      if (mem_rd || mem_wr) begin
        if (sq.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          strobe_t e;
          e = sq.pop_front();
          check("strobe_op", {30'd0, mem_wr, mem_rd}, e.wr ? 32'd2 : 32'd1);
          check("mem_addr", {16'd0, mem_addr}, {16'd0, e.a});
          if (e.wr) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.d});
        end
      end
      if (done) begin
        check("done_stall", {31'd0, stall}, 32'd0);
        if (rq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = rq.pop_front();
          check(r.wr ? "read_data_after_store" : "read_data", {16'd0, read_data},
                {16'd0, r.rdata});
        end
      end
    end
  end

  // One access; request held until done is seen (instruction stays in MEM).
  task automatic do_access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input bit halt_mid);
    int stalls;
    bit got;
    @(posedge clk);
    #1;
    MEM_READ   = !wr;
    MEM_WRITE  = wr;
    addr       = a;
    write_data = d;
    HALT       = 1'b0;
    sq.push_back('{wr: wr, a: a, d: d});
    if (wr) begin
      rq.push_back('{wr: 1'b1, rdata: model_rd});
      ref_mem[a[7:0]] = d;
    end else begin
      model_rd = ref_mem[a[7:0]];
      rq.push_back('{wr: 1'b0, rdata: model_rd});
    end
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (halt_mid && c == 1) HALT = 1'b1;
      if (stall) stalls++;
      if (done) begin
        check("done_cycle", c, LAT + 1);
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    check("stall_cycles", stalls, LAT + 1);
  endtask

  task automatic do_nop();
    @(posedge clk);
    #1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    HALT      = 1'b0;
    addr      = 16'($urandom);
    @(negedge clk);
    check("nop_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_illegal(input logic [15:0] a, input bit both);
    @(posedge clk);
    #1;
    MEM_READ  = 1'b1;
    MEM_WRITE = both;
    HALT      = 1'b0;
    addr      = a;
    @(negedge clk);
    check("illegal_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    exp_err   = 1'b1;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    @(negedge clk);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_no_rd", {31'd0, mem_rd}, 32'd0);
  endtask

  task automatic do_halt_idle();
    @(posedge clk);
    #1;
    HALT      = 1'b1;
    MEM_READ  = 1'b1;
    MEM_WRITE = 1'b0;
    addr      = 16'h0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk);
    #1;
    HALT     = 1'b0;
    MEM_READ = 1'b0;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned r;
      logic [15:0] a;
      r = $urandom_range(0, 9);
      a = 16'($urandom_range(0, 63));
`ifdef DMEM_ALIGN_CHECK_EN
      a[0] = 1'b0;
`endif
      if (r < 2) do_nop();
      else if (r < 6) do_access(1'b0, a, 16'h0, 1'b0);
      else if (r < 9) do_access(1'b1, a, 16'($urandom), 1'b0);
      else do_access(1'b0, a, 16'h0, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    addr       = 16'h0;
    write_data = 16'h0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    HALT       = 1'b0;
    model_rd   = 16'h0;
    exp_err    = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_read_data", {16'd0, read_data}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_access(1'b0, 16'h0010, 16'h0, 1'b0);
    do_access(1'b1, 16'h0020, 16'h1234, 1'b0);
    do_access(1'b0, 16'h0020, 16'h0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    do_illegal(16'h0011, 1'b0);
`else
    do_access(1'b0, 16'h0011, 16'h0, 1'b0);
`endif
    do_nop();
    do_halt_idle();
    do_access(1'b0, 16'h0010, 16'h0, 1'b1);
    random_traffic(40);

    do_illegal(16'h0004, 1'b1);
    random_traffic(15);

    // Reset in BUSY cycle 2 abandons the access.
    @(posedge clk);
    #1;
    MEM_READ  = 1'b1;
    MEM_WRITE = 1'b0;
    HALT      = 1'b0;
    addr      = 16'h0010;
    sq.push_back('{wr: 1'b0, a: 16'h0010, d: 16'h0});
    rq.push_back('{wr: 1'b0, rdata: ref_mem[8'h10]});
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_read_data", {16'd0, read_data}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    MEM_READ = 1'b0;
    exp_err  = 1'b0;
    model_rd = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_access(1'b0, 16'h0010, 16'h0, 1'b0);
    random_traffic(10);

    do_nop();
    repeat (3) @(negedge clk);
    check("strobe_queue_empty", sq.size(), 32'd0);
    check("resp_queue_empty", rq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
